multi_chnnl_trig: RTL and testbench



---
 rtl/multi_chnnl_trig_if.sv | 25 ++
 rtl/multi_chnnl_trig.sv | 125 ++++++++++++
 tb/tb_multi_chnnl_trig.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/multi_chnnl_trig_if.sv
// rtl/multi_chnnl_trig_if.sv - trigger unit bundle: channel samples, config, match/trigger outputs
interface multi_chnnl_trig_if #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 8
);
    logic                  armed;
    logic [NUM_CH-1:0]     ch_lff5;
    logic [NUM_CH-1:0]     ch_hff5;
    logic [5*NUM_CH-1:0]   ch_trig_cfg;
    logic                  comb_or;
    logic [CNT_W-1:0]      qual_cnt;
    logic [NUM_CH-1:0]     ch_trig;
    logic                  triggered;
    logic                  trig_pulse;

    modport master (
        output armed, ch_lff5, ch_hff5, ch_trig_cfg, comb_or, qual_cnt,
        input  ch_trig, triggered, trig_pulse
    );

    modport slave (
        input  armed, ch_lff5, ch_hff5, ch_trig_cfg, comb_or, qual_cnt,
        output ch_trig, triggered, trig_pulse
    );
endinterface

// File: rtl/multi_chnnl_trig.sv
// rtl/multi_chnnl_trig.sv - multi-channel level/edge trigger with AND/OR combine and qualification count
module multi_chnnl_trig #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_chnnl_trig_if.slave     trig_if
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_QUAL, S_TRIG} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   qual_eff;
    logic [NUM_CH-1:0]  low_q, high_q, prev_l, prev_h, neg_s, pos_s;
    logic [NUM_CH-1:0]  cfg_dc, cfg_low, cfg_high, cfg_fall, cfg_rise, ch_en;
    logic [NUM_CH-1:0]  ch_match;
    logic               match;
    logic               edge_en;

    always_comb begin
        cfg_dc   = '0;
        cfg_low  = '0;
        cfg_high = '0;
        cfg_fall = '0;
        cfg_rise = '0;
        ch_en    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_dc[i]   = trig_if.ch_trig_cfg[5*i];
            cfg_low[i]  = trig_if.ch_trig_cfg[5*i+1];
            cfg_high[i] = trig_if.ch_trig_cfg[5*i+2];
            cfg_fall[i] = trig_if.ch_trig_cfg[5*i+3];
            cfg_rise[i] = trig_if.ch_trig_cfg[5*i+4];
            ch_en[i]    = |trig_if.ch_trig_cfg[5*i+1 +: 4];
        end
    end

    assign ch_match = cfg_dc | (cfg_low & low_q) | (cfg_high & high_q)
                    | (cfg_fall & neg_s) | (cfg_rise & pos_s);
    assign trig_if.ch_trig = ch_match;

    // OR mode ignores don't-care-only channels, so an all-don't-care setup never fires
    assign match    = trig_if.comb_or ? |(ch_match & ch_en) : &ch_match;
    assign qual_eff = (trig_if.qual_cnt == '0) ? CNT_ONE : trig_if.qual_cnt;
    assign cnt_inc  = cnt + CNT_ONE;
    // Edges only count once the FSM has left IDLE, which masks the arming cycle itself
    assign edge_en  = trig_if.armed && ((state == S_ARMED) || (state == S_QUAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            cnt                <= '0;
            low_q              <= '0;
            high_q             <= '0;
            prev_l             <= '1;
            prev_h             <= '0;
            neg_s              <= '0;
            pos_s              <= '0;
            trig_if.triggered  <= 1'b0;
            trig_if.trig_pulse <= 1'b0;
        end else begin
            low_q              <= ~trig_if.ch_lff5;
            high_q             <= trig_if.ch_hff5;
            prev_l             <= trig_if.ch_lff5;
            prev_h             <= trig_if.ch_hff5;
            trig_if.trig_pulse <= 1'b0;

            if (!trig_if.armed) begin
                neg_s <= '0;
                pos_s <= '0;
            end else if (edge_en) begin
                neg_s <= neg_s | (prev_l & ~trig_if.ch_lff5);
                pos_s <= pos_s | (~prev_h & trig_if.ch_hff5);
            end

            if (!trig_if.armed) begin
                state             <= S_IDLE;
                cnt               <= '0;
                trig_if.triggered <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_ARMED;
                        cnt   <= '0;
                    end
                    S_ARMED: begin
                        if (match) begin
                            cnt <= CNT_ONE;
                            if (qual_eff <= CNT_ONE) begin
                                state              <= S_TRIG;
                                trig_if.triggered  <= 1'b1;
                                trig_if.trig_pulse <= 1'b1;
                            end else begin
                                state <= S_QUAL;
                            end
                        end
                    end
                    S_QUAL: begin
                        if (match) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == qual_eff) begin
                                state              <= S_TRIG;
                                trig_if.triggered  <= 1'b1;
                                trig_if.trig_pulse <= 1'b1;
                            end
                        end else begin
                            state <= S_ARMED;
                            cnt   <= '0;
                        end
                    end
                    S_TRIG: begin
                        state <= S_TRIG;
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multi_chnnl_trig.sv
// tb/tb_multi_chnnl_trig.sv - scoreboard bench for multi_chnnl_trig
module tb_multi_chnnl_trig;
    typedef struct {
        string      tag;
        logic [4:0] ct;
        logic       trg;
        logic       pls;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    multi_chnnl_trig_if #(.NUM_CH(5), .CNT_W(8)) tif ();

    multi_chnnl_trig #(.NUM_CH(5), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .trig_if (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs after the edge that samples the driven inputs
    task automatic step(input string tag, input logic r, input logic a,
                        input logic [4:0] l, input logic [4:0] h,
                        input logic [4:0] ct, input logic t, input logic p);
        exp_t e;
        @(negedge clk);
        rst         = r;
        tif.armed   = a;
        tif.ch_lff5 = l;
        tif.ch_hff5 = h;
        e.tag = tag;
        e.ct  = ct;
        e.trg = t;
        e.pls = p;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic cfg_set(input logic [24:0] c, input logic o, input logic [7:0] q);
        @(negedge clk);
        tif.ch_trig_cfg = c;
        tif.comb_or     = o;
        tif.qual_cnt    = q;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, ".ch_trig"},    32'(tif.ch_trig),    32'(mon_e.ct));
                chk({mon_e.tag, ".triggered"},  32'(tif.triggered),  32'(mon_e.trg));
                chk({mon_e.tag, ".trig_pulse"}, 32'(tif.trig_pulse), 32'(mon_e.pls));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [4:0] rl, rh;
        rst             = 1'b1;
        tif.armed       = 1'b0;
        tif.ch_lff5     = 5'h1F;
        tif.ch_hff5     = 5'h00;
        tif.ch_trig_cfg = '0;
        tif.comb_or     = 1'b0;
        tif.qual_cnt    = 8'd1;

        step("rst", 1, 0, 5'h1F, 5'h00, 5'h00, 0, 0);
        step("rst", 1, 0, 5'h1F, 5'h00, 5'h00, 0, 0);
        step("idle", 0, 0, 5'h1F, 5'h00, 5'h00, 0, 0);

        // Falling edge on ch0, AND mode, qual 1
        cfg_set({5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b01000}, 1'b0, 8'd1);
        step("fe_arm",    0, 1, 5'h1F, 5'h00, 5'h1E, 0, 0);
        step("fe_arm",    0, 1, 5'h1F, 5'h00, 5'h1E, 0, 0);
        step("fe_k",      0, 1, 5'h1E, 5'h00, 5'h1F, 0, 0);
        step("fe_k1",     0, 1, 5'h1E, 5'h00, 5'h1F, 1, 1);
        step("fe_k2",     0, 1, 5'h1E, 5'h00, 5'h1F, 1, 0);
        step("fe_hold",   0, 1, 5'h1E, 5'h00, 5'h1F, 1, 0);
        step("fe_disarm", 0, 0, 5'h1E, 5'h00, 5'h1E, 0, 0);
        repeat (5) step("fe_rearm", 0, 1, 5'h1E, 5'h00, 5'h1E, 0, 0);
        step("fe_off",    0, 0, 5'h1F, 5'h00, 5'h1E, 0, 0);

        // High level on ch1, OR mode, qual 4
        cfg_set({5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000}, 1'b1, 8'd4);
        step("q_arm", 0, 1, 5'h1F, 5'h00, 5'h00, 0, 0);
        repeat (3) step("q_b1", 0, 1, 5'h1F, 5'h02, 5'h02, 0, 0);
        step("q_gap", 0, 1, 5'h1F, 5'h00, 5'h00, 0, 0);
        repeat (4) step("q_b2", 0, 1, 5'h1F, 5'h02, 5'h02, 0, 0);
        step("q_trig", 0, 1, 5'h1F, 5'h00, 5'h00, 1, 1);
        step("q_hold", 0, 1, 5'h1F, 5'h00, 5'h00, 1, 0);
        step("q_off",  0, 0, 5'h1F, 5'h00, 5'h00, 0, 0);

        // Reset in the middle of qualification restarts the count
        step("r_arm", 0, 1, 5'h1F, 5'h00, 5'h00, 0, 0);
        repeat (3) step("r_q", 0, 1, 5'h1F, 5'h02, 5'h02, 0, 0);
        step("r_rst",  1, 1, 5'h1F, 5'h02, 5'h00, 0, 0);
        step("r_idle", 0, 1, 5'h1F, 5'h02, 5'h02, 0, 0);
        repeat (3) step("r_cnt", 0, 1, 5'h1F, 5'h02, 5'h02, 0, 0);
        step("r_trig", 0, 1, 5'h1F, 5'h02, 5'h02, 1, 1);
        step("r_off",  0, 0, 5'h1F, 5'h00, 5'h00, 0, 0);

        // OR mode with only don't-care channels never fires
        cfg_set({5{5'b00001}}, 1'b1, 8'd1);
        for (int i = 0; i < 100; i++) begin
            rl = 5'($urandom_range(0, 31));
            rh = 5'($urandom_range(0, 31));
            step("or_x", 0, 1, rl, rh, 5'h1F, 0, 0);
        end
        step("or_off", 0, 0, 5'h1F, 5'h00, 5'h1F, 0, 0);

        // Rising edge on ch2 coincident with arming is ignored; a later one fires
        cfg_set({5'b00001, 5'b00001, 5'b10000, 5'b00001, 5'b00001}, 1'b0, 8'd1);
        step("ae_arm", 0, 1, 5'h1F, 5'h04, 5'h1B, 0, 0);
        repeat (4) step("ae_hold", 0, 1, 5'h1F, 5'h04, 5'h1B, 0, 0);
        step("ae_off",   0, 0, 5'h1F, 5'h00, 5'h1B, 0, 0);
        step("ae_arm2",  0, 1, 5'h1F, 5'h00, 5'h1B, 0, 0);
        step("ae_wait",  0, 1, 5'h1F, 5'h00, 5'h1B, 0, 0);
        step("ae_rise",  0, 1, 5'h1F, 5'h04, 5'h1F, 0, 0);
        step("ae_trig",  0, 1, 5'h1F, 5'h04, 5'h1F, 1, 1);
        step("ae_hold2", 0, 1, 5'h1F, 5'h04, 5'h1F, 1, 0);
        step("ae_off2",  0, 0, 5'h1F, 5'h00, 5'h1B, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
